// File: rtl/pc_branch_unit.sv
// Fetch PC sequencer with branch target generation, wrap detection and a
// saturating taken-branch counter. BOOT -> RUN <-> REDIR control FSM.
module pc_branch_unit #(
   parameter int unsigned          XLEN     = 32,
   parameter int unsigned          IMM_W    = 14,
   parameter int unsigned          PC_STEP  = 4,
   parameter logic [XLEN-1:0]      RESET_PC = '0,
   parameter int unsigned          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             br_valid,
   input  logic             br_taken,
   input  logic [XLEN-1:0]  br_pc,
   input  logic [IMM_W-1:0] br_imm,
   input  logic             sext,
   input  logic             abs,
   output logic [XLEN-1:0]  pc,
   output logic             pc_valid,
   output logic             redirect,
   output logic [XLEN-1:0]  target,
   output logic             wrap,
   output logic [CNT_W-1:0] taken_cnt
);

   localparam int unsigned EXT_W = XLEN - IMM_W;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      REDIR = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [XLEN-1:0]  pc_next, target_next;
   logic             pc_valid_next, redirect_next, wrap_next;
   logic [CNT_W-1:0] cnt_next;

   logic [XLEN-1:0]  ext_c, base_c, tgt_c, pc_inc_c;
   logic [XLEN:0]    sum_c;
   logic             wrap_c;

   // Target adder; the extra sum bit is the unsigned carry-out.
   always_comb begin
      ext_c    = sext ? {{EXT_W{br_imm[IMM_W-1]}}, br_imm} : {{EXT_W{1'b0}}, br_imm};
      base_c   = abs ? '0 : br_pc;
      sum_c    = {1'b0, base_c} + {1'b0, ext_c};
      tgt_c    = sum_c[XLEN-1:0];
      pc_inc_c = pc + XLEN'(PC_STEP);
      if (abs && !sext)
         wrap_c = 1'b0;
      else if (!sext)
         wrap_c = sum_c[XLEN];
      else
         wrap_c = ext_c[XLEN-1] ? ~sum_c[XLEN] : sum_c[XLEN];
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_next    = state;
      pc_next       = pc;
      pc_valid_next = 1'b0;
      redirect_next = 1'b0;
      target_next   = target;
      wrap_next     = wrap;
      cnt_next      = taken_cnt;
      case (state)
         BOOT: begin
            state_next    = RUN;
            pc_valid_next = 1'b1;
         end
         RUN: begin
            if (br_valid && br_taken) begin
               state_next    = REDIR;
               pc_next       = tgt_c;
               target_next   = tgt_c;
               wrap_next     = wrap_c;
               redirect_next = 1'b1;
               if (taken_cnt != {CNT_W{1'b1}})
                  cnt_next = taken_cnt + CNT_W'(1);
            end else begin
               pc_valid_next = 1'b1;
               if (!stall)
                  pc_next = pc_inc_c;
            end
         end
         REDIR: begin
            // Branches seen here are wrong-path and dropped.
            state_next    = RUN;
            pc_valid_next = 1'b1;
            if (!stall)
               pc_next = pc_inc_c;
         end
         default: state_next = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= BOOT;
         pc        <= RESET_PC;
         pc_valid  <= 1'b0;
         redirect  <= 1'b0;
         target    <= '0;
         wrap      <= 1'b0;
         taken_cnt <= '0;
      end else begin
         state     <= state_next;
         pc        <= pc_next;
         pc_valid  <= pc_valid_next;
         redirect  <= redirect_next;
         target    <= target_next;
         wrap      <= wrap_next;
         taken_cnt <= cnt_next;
      end
   end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- XLEN, 32, address width
- IMM_W, 14, branch immediate width
- PC_STEP, 4, sequential PC increment
- RESET_PC, 0, PC value loaded by reset
- CNT_W, 16, taken-branch counter width
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- stall, in, 1, hold sequential PC advance
- br_valid, in, 1, branch resolution presented this cycle
- br_taken, in, 1, presented branch is taken
- br_pc, in, XLEN, PC of resolving branch
- br_imm, in, IMM_W, branch offset/target immediate
- sext, in, 1, 1 = sign-extend br_imm, 0 = zero-extend (legacy mode)
- abs, in, 1, 1 = target is extended br_imm alone, 0 = br_pc + extended br_imm
- pc, out, XLEN, current fetch PC (registered)
- pc_valid, out, 1, pc is a valid fetch address this cycle
- redirect, out, 1, one-cycle pulse: pc was loaded from a branch target
- target, out, XLEN, last computed taken target (registered)
- wrap, out, 1, last taken target wrapped modulo 2^XLEN
- taken_cnt, out, CNT_W, saturating count of accepted taken branches
REQ-003 There SHALL be one clock; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 ext SHALL be br_imm sign-extended to XLEN when sext=1, zero-extended when sext=0.
REQ-005 Combinational target SHALL be (abs ? 0 : br_pc) + ext, modulo 2^XLEN.
REQ-006 wrap_next SHALL be 1 when the true sum leaves [0, 2^XLEN-1]: unsigned carry-out when sext=0; when sext=1, carry-out with non-negative ext or no carry-out with negative ext; 0 when abs=1 and sext=0.
REQ-007 FSM states SHALL be BOOT, RUN, REDIR; all outputs registered.
REQ-008 BOOT: entered on reset; pc_valid=0; br_valid ignored; next state RUN unconditionally; pc unchanged.
REQ-009 RUN, accepted taken branch (br_valid=1, br_taken=1): next cycle pc=target, target/wrap updated, redirect=1, pc_valid=0, state REDIR; stall does not block it.
REQ-010 RUN, no taken branch, stall=0: pc <= pc + PC_STEP modulo 2^XLEN (all-ones region wraps to low addresses); pc_valid=1.
REQ-011 RUN, no taken branch, stall=1: pc, target, wrap hold; pc_valid=1.
REQ-012 br_valid=1 with br_taken=0 SHALL behave as no branch; target, wrap, taken_cnt unchanged.
REQ-013 REDIR: br_valid ignored (wrong-path); stall=0 -> pc advances per REQ-010 and state RUN; stall=1 -> pc holds and state RUN; pc_valid=1 in the cycle after REDIR.
REQ-014 redirect SHALL be high exactly one cycle per accepted taken branch; 0 otherwise.
REQ-015 taken_cnt SHALL increment by 1 per accepted taken branch and saturate at 2^CNT_W-1.

Reset
REQ-016 With rst_n=0, immediately and independent of clk: pc=RESET_PC, pc_valid=0, redirect=0, target=0, wrap=0, taken_cnt=0, state=BOOT.
REQ-017 Reset asserted mid-redirect SHALL discard the pending target; the first cycle after release SHALL be BOOT.

Verification
REQ-018 Reset release, stall=0, no branches -> pc_valid=0 one cycle, then pc 0x0,0x4,0x8,... with pc_valid=1.
REQ-019 pc=0x100, br_pc=0x100, br_imm=0x3FFC, sext=1, abs=0, taken -> pc=0xFC, redirect=1 one cycle, pc_valid=0, wrap=0; next cycle pc=0x100, pc_valid=1.
REQ-020 Same stimulus with sext=0 -> target=0x40FC, wrap=0; br_pc=0xFFFFFFF0, br_imm=0x20, sext=0 -> target=0x10, wrap=1.
REQ-021 stall=1 held three cycles plus taken branch in cycle two (abs=1, br_imm=0x40, sext=0) -> pc held, then pc=0x40, redirect=1; taken branch in REDIR cycle ignored, taken_cnt increments once.
REQ-022 CNT_W=2, five taken branches each separated by two idle cycles -> taken_cnt 1,2,3,3,3; pc=0xFFFFFFFC, stall=0 -> next pc=0x0; rst_n pulsed low mid-REDIR -> all outputs per REQ-016 immediately.
